// File: rtl/cpu_pkg.sv
// Shared definitions for the five-stage pipeline:
// control-bundle layout and operand-forwarding select codes.
package cpu_pkg;

  localparam int REG_WRITE  = 0;
  localparam int MEM_READ   = 1;
  localparam int MEM_WRITE  = 2;
  localparam int MEM_TO_REG = 3;
  localparam int ALU_SRC    = 4;
  localparam int REG_DST    = 5;
  localparam int ALU_OP     = 6;
  localparam int ALU_OP_W   = 4;
  localparam int CTRL_W     = ALU_OP + ALU_OP_W;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EXM = 2'b01;
  localparam logic [1:0] FWD_MWB = 2'b10;

  typedef logic [CTRL_W-1:0] ctrl_t;

endpackage

// File: rtl/forward_unit.sv
// Operand forwarding select for one EX source register.
// EX/MEM wins over MEM/WB; register 0 is never forwarded.
module forward_unit
  import cpu_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic            en,
  input  logic [RA_W-1:0] src,
  input  logic            exm_reg_write,
  input  logic [RA_W-1:0] exm_dest,
  input  logic            mwb_reg_write,
  input  logic [RA_W-1:0] mwb_dest,
  output logic [1:0]      sel
);

  logic exm_hit;
  logic mwb_hit;

  always_comb begin
    exm_hit = exm_reg_write & (|exm_dest)
            & (exm_dest == src);
    mwb_hit = mwb_reg_write & (|mwb_dest)
            & (mwb_dest == src);
    sel = FWD_REG;
    priority case (1'b1)
      !en:     sel = FWD_REG;
      exm_hit: sel = FWD_EXM;
      mwb_hit: sel = FWD_MWB;
      default: sel = FWD_REG;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion,
// branch flush, forwarding selects and event counters.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [WIDTH-1:0] id_pc,
  input  logic [WIDTH-1:0] id_rs_val,
  input  logic [WIDTH-1:0] id_rt_val,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic [RA_W-1:0]  id_dest,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic             flush,
  input  logic             exm_reg_write,
  input  logic [RA_W-1:0]  exm_dest,
  input  logic             mwb_reg_write,
  input  logic [RA_W-1:0]  mwb_dest,
  output logic             stall_if_id,
  output logic             ex_valid,
  output logic [WIDTH-1:0] ex_pc,
  output logic [WIDTH-1:0] ex_rs_val,
  output logic [WIDTH-1:0] ex_rt_val,
  output logic [WIDTH-1:0] ex_imm,
  output logic [RA_W-1:0]  ex_rs,
  output logic [RA_W-1:0]  ex_rt,
  output logic [RA_W-1:0]  ex_dest,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] rs_val_q, rs_val_d;
  logic [WIDTH-1:0] rt_val_q, rt_val_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [RA_W-1:0]  rs_q, rs_d;
  logic [RA_W-1:0]  rt_q, rt_d;
  logic [RA_W-1:0]  dest_q, dest_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lu;
  logic             stall;

  always_comb begin
    // rt is compared even for I-type readers; extra stalls are harmless
    lu = id_valid & valid_q & ctrl_q[MEM_READ] & (|dest_q)
       & ((dest_q == id_rs) | (dest_q == id_rt));
    stall = lu & ~flush;

    pc_d     = id_pc;
    rs_val_d = id_rs_val;
    rt_val_d = id_rt_val;
    imm_d    = id_imm;
    rs_d     = id_rs;
    rt_d     = id_rt;
    dest_d   = id_dest;
    valid_d  = id_valid & ~flush & ~lu;
    ctrl_d   = valid_d ? id_ctrl : '0;

    stall_cnt_d = stall_cnt_q;
    if (stall && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);

    flush_cnt_d = flush_cnt_q;
    if (flush && !(&flush_cnt_q))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs_val_q    <= '0;
      rt_val_q    <= '0;
      imm_q       <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      dest_q      <= '0;
      ctrl_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs_val_q    <= rs_val_d;
      rt_val_q    <= rt_val_d;
      imm_q       <= imm_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      dest_q      <= dest_d;
      ctrl_q      <= ctrl_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  forward_unit #(.RA_W(RA_W)) u_fwd_a (
    .en            (valid_q),
    .src           (rs_q),
    .exm_reg_write (exm_reg_write),
    .exm_dest      (exm_dest),
    .mwb_reg_write (mwb_reg_write),
    .mwb_dest      (mwb_dest),
    .sel           (fwd_a_sel)
  );

  forward_unit #(.RA_W(RA_W)) u_fwd_b (
    .en            (valid_q),
    .src           (rt_q),
    .exm_reg_write (exm_reg_write),
    .exm_dest      (exm_dest),
    .mwb_reg_write (mwb_reg_write),
    .mwb_dest      (mwb_dest),
    .sel           (fwd_b_sel)
  );

  assign stall_if_id = stall;
  assign ex_valid    = valid_q;
  assign ex_pc       = pc_q;
  assign ex_rs_val   = rs_val_q;
  assign ex_rt_val   = rt_val_q;
  assign ex_imm      = imm_q;
  assign ex_rs       = rs_q;
  assign ex_rt       = rt_q;
  assign ex_dest     = dest_q;
  assign ex_ctrl     = ctrl_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard/forward cases plus
// random traffic against a behavioural pipeline model.
module tb_id_ex_stage;
  import cpu_pkg::*;

  localparam int W  = 32;
  localparam int RA = 5;
  localparam int CW = 10;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 0;
  logic rst_n = 0;
  logic id_valid = 0;
  logic [W-1:0] id_pc = 0, id_rs_val = 0, id_rt_val = 0, id_imm = 0;
  logic [RA-1:0] id_rs = 0, id_rt = 0, id_dest = 0;
  logic [CTRL_W-1:0] id_ctrl = 0;
  logic flush = 0;
  logic exm_reg_write = 0, mwb_reg_write = 0;
  logic [RA-1:0] exm_dest = 0, mwb_dest = 0;
  logic stall_if_id, ex_valid;
  logic [W-1:0] ex_pc, ex_rs_val, ex_rt_val, ex_imm;
  logic [RA-1:0] ex_rs, ex_rt, ex_dest;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic v;
    logic [W-1:0] pc, rsv, rtv, imm;
    logic [RA-1:0] rs, rt, dst;
    logic [CTRL_W-1:0] ctrl;
    int scnt, fcnt;
  } model_t;
  model_t m;

  always #5 clk = ~clk;

  id_ex_stage #(.WIDTH(W), .RA_W(RA), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt),
    .id_dest(id_dest), .id_ctrl(id_ctrl), .flush(flush),
    .exm_reg_write(exm_reg_write), .exm_dest(exm_dest),
    .mwb_reg_write(mwb_reg_write), .mwb_dest(mwb_dest),
    .stall_if_id(stall_if_id), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_dest(ex_dest), .ex_ctrl(ex_ctrl),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m = '{v: 0, pc: 0, rsv: 0, rtv: 0, imm: 0, rs: 0, rt: 0,
          dst: 0, ctrl: 0, scnt: 0, fcnt: 0};
  endfunction

  function automatic bit model_lu();
    return id_valid && m.v && m.ctrl[MEM_READ] && m.dst != 0 &&
           (m.dst == id_rs || m.dst == id_rt);
  endfunction

  function automatic logic [1:0] model_fwd(logic [RA-1:0] src);
    if (!m.v) return 2'd0;
    if (exm_reg_write && exm_dest != 0 && exm_dest == src) return 2'd1;
    if (mwb_reg_write && mwb_dest != 0 && mwb_dest == src) return 2'd2;
    return 2'd0;
  endfunction

  task automatic check_regs(string tag);
    chk({tag, ".valid"}, 64'(ex_valid), 64'(m.v));
    chk({tag, ".pc"}, 64'(ex_pc), 64'(m.pc));
    chk({tag, ".rsv"}, 64'(ex_rs_val), 64'(m.rsv));
    chk({tag, ".rtv"}, 64'(ex_rt_val), 64'(m.rtv));
    chk({tag, ".imm"}, 64'(ex_imm), 64'(m.imm));
    chk({tag, ".rs"}, 64'(ex_rs), 64'(m.rs));
    chk({tag, ".rt"}, 64'(ex_rt), 64'(m.rt));
    chk({tag, ".dst"}, 64'(ex_dest), 64'(m.dst));
    chk({tag, ".ctrl"}, 64'(ex_ctrl), 64'(m.ctrl));
    chk({tag, ".scnt"}, 64'(stall_cnt), 64'(m.scnt));
    chk({tag, ".fcnt"}, 64'(flush_cnt), 64'(m.fcnt));
  endtask

  // one clock: check combinational outputs, clock, advance model, check
  task automatic step(string tag);
    bit lu;
    @(negedge clk);
    lu = model_lu();
    chk({tag, ".stall"}, 64'(stall_if_id), 64'(lu && !flush));
    chk({tag, ".fwa"}, 64'(fwd_a_sel), 64'(model_fwd(m.rs)));
    chk({tag, ".fwb"}, 64'(fwd_b_sel), 64'(model_fwd(m.rt)));
    @(posedge clk);
    m.pc = id_pc; m.rsv = id_rs_val; m.rtv = id_rt_val; m.imm = id_imm;
    m.rs = id_rs; m.rt = id_rt; m.dst = id_dest;
    if (flush) begin
      m.v = 0; m.ctrl = 0;
      if (m.fcnt < CMAX) m.fcnt++;
    end else if (lu) begin
      m.v = 0; m.ctrl = 0;
      if (m.scnt < CMAX) m.scnt++;
    end else begin
      m.v = id_valid;
      m.ctrl = id_valid ? id_ctrl : '0;
    end
    #1;
    check_regs(tag);
  endtask

  task automatic set_id(logic v, logic [RA-1:0] rs, logic [RA-1:0] rt,
                        logic [RA-1:0] dst, logic [CTRL_W-1:0] c);
    id_valid = v; id_rs = rs; id_rt = rt; id_dest = dst; id_ctrl = c;
    id_pc = $urandom; id_rs_val = $urandom;
    id_rt_val = $urandom; id_imm = $urandom;
  endtask

  task automatic set_wb(logic ew, logic [RA-1:0] ed,
                        logic mw, logic [RA-1:0] md);
    exm_reg_write = ew; exm_dest = ed;
    mwb_reg_write = mw; mwb_dest = md;
  endtask

  localparam logic [CTRL_W-1:0] LW =
    CTRL_W'((1 << MEM_READ) | (1 << REG_WRITE) | (1 << MEM_TO_REG));
  localparam logic [CTRL_W-1:0] ADD =
    CTRL_W'((1 << REG_WRITE) | (1 << REG_DST) | (2 << ALU_OP));

  initial begin
    model_reset();
    #12;
    check_regs("rst");
    chk("rst.stall", 64'(stall_if_id), 64'd0);
    rst_n = 1;

    // lw $8 then reader of $8
    set_wb(0, 0, 0, 0);
    set_id(1, 5'd1, 5'd2, 5'd8, LW);
    step("lw8");
    set_id(1, 5'd8, 5'd3, 5'd4, ADD);
    step("lu");
    chk("lu.bubble", 64'(ex_valid), 64'd0);
    chk("lu.scnt", 64'(stall_cnt), 64'd1);
    set_wb(1, 5'd8, 0, 0);
    step("lu.cap");
    chk("lu.rs", 64'(ex_rs), 64'd8);
    chk("lu.fwa", 64'(fwd_a_sel), 64'(FWD_EXM));

    // flush together with a load-use hazard
    set_wb(0, 0, 0, 0);
    set_id(1, 5'd1, 5'd2, 5'd7, LW);
    step("lw7");
    set_id(1, 5'd3, 5'd7, 5'd4, ADD);
    flush = 1;
    step("flu");
    chk("flu.valid", 64'(ex_valid), 64'd0);
    chk("flu.scnt", 64'(stall_cnt), 64'd1);
    chk("flu.fcnt", 64'(flush_cnt), 64'd1);
    flush = 0;

    // forwarding priority and register 0
    set_id(1, 5'd9, 5'd0, 5'd4, ADD);
    step("f9");
    set_wb(1, 5'd9, 1, 5'd9);
    #1 chk("f.exm", 64'(fwd_a_sel), 64'(FWD_EXM));
    set_wb(0, 5'd9, 1, 5'd9);
    #1 chk("f.mwb", 64'(fwd_a_sel), 64'(FWD_MWB));
    set_wb(1, 5'd0, 1, 5'd0);
    #1 chk("f.r0b", 64'(fwd_b_sel), 64'(FWD_REG));
    set_id(1, 5'd0, 5'd0, 5'd4, ADD);
    step("f0");
    chk("f0.a", 64'(fwd_a_sel), 64'(FWD_REG));

    // lw $0 never stalls a reader of $0
    set_wb(0, 0, 0, 0);
    set_id(1, 5'd1, 5'd2, 5'd0, LW);
    step("lw0");
    set_id(1, 5'd0, 5'd0, 5'd5, ADD);
    step("lw0.rd");
    chk("lw0.valid", 64'(ex_valid), 64'd1);

    // random traffic on a small register set to provoke hazards
    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(0, 3) != 0, RA'($urandom_range(0, 3)),
             RA'($urandom_range(0, 3)), RA'($urandom_range(0, 3)),
             ($urandom_range(0, 1) != 0) ? LW : CTRL_W'($urandom));
      flush = $urandom_range(0, 9) == 0;
      set_wb($urandom_range(0, 1) != 0, RA'($urandom_range(0, 3)),
             $urandom_range(0, 1) != 0, RA'($urandom_range(0, 3)));
      step("rnd");
    end
    flush = 0;

    // asynchronous reset mid-stall with live state
    rst_n = 0; model_reset(); #3 rst_n = 1;
    set_wb(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      set_id(1, 5'd1, 5'd2, 5'd6, LW);
      step("pre.lw");
      set_id(1, 5'd6, 5'd2, 5'd3, ADD);
      step("pre.lu");
    end
    set_id(1, 5'd1, 5'd2, 5'd6, LW);
    step("pre.v");
    chk("pre.scnt5", 64'(stall_cnt), 64'd5);
    set_id(1, 5'd6, 5'd2, 5'd3, ADD);
    @(negedge clk); #2;
    rst_n = 0;
    model_reset();
    #1;
    check_regs("arst");
    chk("arst.stall", 64'(stall_if_id), 64'd0);
    #4 rst_n = 1;

    // counter saturation
    for (int i = 0; i < CMAX + 1; i++) begin
      set_id(1, 5'd1, 5'd2, 5'd6, LW);
      step("sat.lw");
      set_id(1, 5'd2, 5'd6, 5'd3, ADD);
      step("sat.lu");
      if (i == CMAX - 1)
        chk("sat.full", 64'(stall_cnt), 64'(CMAX));
    end
    chk("sat.hold", 64'(stall_cnt), 64'(CMAX));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
